// File: rtl/iceboard_pkg.sv
// iceboard_pkg -- shared types and constants for the iceboard UART TX arbiter.
//
// Contents:
//   ICEBOARD_BYTE_W                 byte width on every data path (8)
//   ICEBOARD_GID_W                  width of the grant index (3, covers up to 8 requesters)
//   ICEBOARD_DEFAULT_MAX_FRAME_LEN  default frame length cap (16 bytes)
//   arb_state_t                     arbiter FSM states; ST_ABORT only exists when
//                                   ICEBOARD_ARB_TIMEOUT_EN is defined
//   wrap_inc()                      modulo-n increment of a grant index
package iceboard_pkg;

  localparam int ICEBOARD_BYTE_W                = 8;
  localparam int ICEBOARD_GID_W                 = 3;
  localparam int ICEBOARD_DEFAULT_MAX_FRAME_LEN = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_XFER  = 2'd1
`ifdef ICEBOARD_ARB_TIMEOUT_EN
    ,
    ST_ABORT = 2'd2
`endif
  } arb_state_t;

  // Next round-robin position after index v among n requesters.
  function automatic logic [ICEBOARD_GID_W-1:0] wrap_inc(
    input logic [ICEBOARD_GID_W-1:0] v,
    input int                        n
  );
    return (int'(v) == n - 1) ? '0 : v + 1'b1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick -- combinational round-robin selector.
//
// Picks the first set bit of req at or after ptr, wrapping modulo N.
//
// Ports:
//   req  in  N  request vector
//   ptr  in  3  search start position (must be < N)
//   idx  out 3  selected index (0 when nothing is requested)
//   any  out 1  at least one request bit is set
module rr_pick
  import iceboard_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]                req,
  input  logic [ICEBOARD_GID_W-1:0]   ptr,
  output logic [ICEBOARD_GID_W-1:0]   idx,
  output logic                        any
);

  int best_dist;

  // Each requester's distance ahead of ptr; the smallest distance wins.
  // Scanning by requester index keeps every select constant after unrolling.
  always_comb begin
    idx       = '0;
    any       = 1'b0;
    best_dist = N;
    for (int k = 0; k < N; k++) begin
      if (req[k] && (((k - int'(ptr) + N) % N) < best_dist)) begin
        best_dist = (k - int'(ptr) + N) % N;
        idx       = ICEBOARD_GID_W'(k);
        any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/iceboard_tx_arbiter.sv
// iceboard_tx_arbiter -- frame-level round-robin arbiter for the shared
// iceboard UART transmit path.
//
// A requester is granted in IDLE, then owns the TX path for a whole frame
// (until a req_last beat or MAX_FRAME_LEN beats). One IDLE cycle separates
// frames, during which the next owner is picked round-robin.
//
// Parameters:
//   NUM_REQ         number of requesters (2..8)
//   MAX_FRAME_LEN   byte cap per granted frame (1..255)
//   TIMEOUT_CYCLES  mid-frame stall limit (only used with ICEBOARD_ARB_TIMEOUT_EN)
//
// Ports:
//   clk          in   1          rising-edge clock
//   reset_n      in   1          async active-low reset
//   req_valid    in   NUM_REQ    per-requester byte valid
//   req_data     in   8*NUM_REQ  per-requester byte, lane i at [8i+7:8i]
//   req_last     in   NUM_REQ    final byte of a frame
//   req_ready    out  NUM_REQ    per-requester byte accept
//   tx_valid     out  1          byte valid toward the UART
//   tx_data      out  8          byte toward the UART
//   tx_ready     in   1          UART accepts a byte
//   grant_id     out  3          current owner, valid while busy
//   busy         out  1          frame in progress
//   frame_trunc  out  1          one-cycle pulse after a frame is cut
//
// Build option:
//   ICEBOARD_ARB_TIMEOUT_EN  adds a stall counter and ABORT state that drop an
//                            owner whose req_valid stays low for TIMEOUT_CYCLES
//                            XFER cycles. Without it a stalled owner keeps the
//                            grant indefinitely.
module iceboard_tx_arbiter
  import iceboard_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int MAX_FRAME_LEN  = ICEBOARD_DEFAULT_MAX_FRAME_LEN,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic [NUM_REQ-1:0]                   req_valid,
  input  logic [ICEBOARD_BYTE_W*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]                   req_last,
  output logic [NUM_REQ-1:0]                   req_ready,
  output logic                                 tx_valid,
  output logic [ICEBOARD_BYTE_W-1:0]           tx_data,
  input  logic                                 tx_ready,
  output logic [ICEBOARD_GID_W-1:0]            grant_id,
  output logic                                 busy,
  output logic                                 frame_trunc
);

  // beat_cnt value on the frame's final permitted beat
  localparam logic [7:0] FRAME_LAST = 8'(MAX_FRAME_LEN - 1);

  arb_state_t                         state;
  logic [ICEBOARD_GID_W-1:0]          rr_ptr;
  logic [7:0]                         beat_cnt;

  logic [NUM_REQ-1:0][ICEBOARD_BYTE_W-1:0] lane_data;
  logic                               sel_valid;
  logic                               sel_last;
  logic [ICEBOARD_BYTE_W-1:0]         sel_data;
  logic [ICEBOARD_GID_W-1:0]          pick_idx;
  logic                               pick_any;
  logic [ICEBOARD_GID_W-1:0]          next_ptr;
  logic                               in_xfer;
  logic                               beat;
  logic                               at_limit;

`ifdef ICEBOARD_ARB_TIMEOUT_EN
  localparam logic [9:0] STALL_LAST = 10'(TIMEOUT_CYCLES - 1);
  logic [9:0] stall_cnt;
`else
  // The stall limit has no effect in this build.
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

  assign lane_data = req_data;

  // Owner lane mux. Compared by index so grant_id needs no range trimming.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_id == ICEBOARD_GID_W'(k)) begin
        sel_valid = req_valid[k];
        sel_last  = req_last[k];
        sel_data  = lane_data[k];
      end
    end
  end

  rr_pick #(.N(NUM_REQ)) u_rr_pick (
    .req (req_valid),
    .ptr (rr_ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Data path is a pass-through while a frame is owned, so the owner sees
  // tx_ready in the same cycle and no byte is buffered inside the arbiter.
  assign in_xfer  = (state == ST_XFER);
  assign tx_valid = in_xfer & sel_valid;
  assign tx_data  = in_xfer ? sel_data : '0;
  assign beat     = tx_valid & tx_ready;
  assign at_limit = (beat_cnt == FRAME_LAST);
  assign next_ptr = wrap_inc(grant_id, NUM_REQ);

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_ready
    assign req_ready[g] = in_xfer && (grant_id == ICEBOARD_GID_W'(g)) && tx_ready;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      grant_id    <= '0;
      rr_ptr      <= '0;
      beat_cnt    <= '0;
      busy        <= 1'b0;
      frame_trunc <= 1'b0;
`ifdef ICEBOARD_ARB_TIMEOUT_EN
      stall_cnt   <= '0;
`endif
    end else begin
      frame_trunc <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            grant_id <= pick_idx;
            busy     <= 1'b1;
            beat_cnt <= '0;
            state    <= ST_XFER;
`ifdef ICEBOARD_ARB_TIMEOUT_EN
            stall_cnt <= '0;
`endif
          end
        end

        ST_XFER: begin
          if (beat) begin
            beat_cnt <= beat_cnt + 8'd1;
`ifdef ICEBOARD_ARB_TIMEOUT_EN
            stall_cnt <= '0;
`endif
            // A last byte on the limit beat is a normal end, not a cut.
            if (sel_last || at_limit) begin
              state       <= ST_IDLE;
              busy        <= 1'b0;
              rr_ptr      <= next_ptr;
              frame_trunc <= ~sel_last;
            end
          end
`ifdef ICEBOARD_ARB_TIMEOUT_EN
          else if (!sel_valid) begin
            // Owner has nothing to send; a held-off byte (tx_ready low) is
            // not a stall.
            if (stall_cnt == STALL_LAST) begin
              state       <= ST_ABORT;
              busy        <= 1'b0;
              rr_ptr      <= next_ptr;
              frame_trunc <= 1'b1;
            end else begin
              stall_cnt <= stall_cnt + 10'd1;
            end
          end
`endif
        end

`ifdef ICEBOARD_ARB_TIMEOUT_EN
        ST_ABORT: state <= ST_IDLE;
`endif

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iceboard_tx_arbiter.sv
// Directed bench for iceboard_tx_arbiter (NUM_REQ=4, MAX_FRAME_LEN=16).
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_iceboard_tx_arbiter;

  localparam int NREQ = 4;
  localparam int MAXF = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_last = '0;
  logic [3:0]  req_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b0;
  logic [2:0]  grant_id;
  logic        busy;
  logic        frame_trunc;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  iceboard_tx_arbiter #(
    .NUM_REQ(NREQ), .MAX_FRAME_LEN(MAXF), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .grant_id(grant_id), .busy(busy), .frame_trunc(frame_trunc)
  );

  typedef struct {
    bit        rst;
    bit [3:0]  vld;
    bit [3:0]  lst;
    bit [31:0] dat;
    bit        rdy;
    bit        e_tv;
    bit [7:0]  e_td;
    bit        e_busy;
    bit [2:0]  e_gid;
    bit [3:0]  e_rr;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(bit rst, bit [3:0] vld, bit [3:0] lst, bit [31:0] dat, bit rdy,
                              bit tv, bit [7:0] td, bit bsy, bit [2:0] gid, bit [3:0] rr);
    vec_t v;
    v.rst = rst; v.vld = vld; v.lst = lst; v.dat = dat; v.rdy = rdy;
    v.e_tv = tv; v.e_td = td; v.e_busy = bsy; v.e_gid = gid; v.e_rr = rr;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Requester id offers byte k of an nbytes frame (nothing once k reaches nbytes).
  task automatic drive_lane(input int id, input int k, input int nbytes);
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    if (k < nbytes) begin
      req_valid = 4'(1 << id);
      req_last  = (k == nbytes - 1) ? 4'(1 << id) : 4'd0;
      req_data  = 32'(8'(8'h80 + k)) << (8 * id);
    end
  endtask

  // Single requester streams nbytes; the bench expects cuts every MAXF bytes,
  // one IDLE cycle before each frame, and a trunc pulse in the IDLE cycle
  // that follows a cut.
  task automatic send_long(input int id, input int nbytes);
    int   k = 0;
    int   n;
    logic cut = 1'b0;
    tx_ready = 1'b1;
    while (k < nbytes) begin
      n = (nbytes - k > MAXF) ? MAXF : nbytes - k;
      @(negedge clk); drive_lane(id, k, nbytes); #1;
      chk($sformatf("long%0d idle tx_valid k=%0d", id, k), 32'(tx_valid), 0);
      chk($sformatf("long%0d idle busy k=%0d", id, k), 32'(busy), 0);
      chk($sformatf("long%0d idle frame_trunc k=%0d", id, k), 32'(frame_trunc), 32'(cut));
      for (int j = 0; j < n; j++) begin
        @(negedge clk); drive_lane(id, k, nbytes); #1;
        chk($sformatf("long%0d tx_valid k=%0d", id, k), 32'(tx_valid), 1);
        chk($sformatf("long%0d tx_data k=%0d", id, k), 32'(tx_data), 32'(8'(8'h80 + k)));
        chk($sformatf("long%0d grant_id k=%0d", id, k), 32'(grant_id), 32'(id));
        chk($sformatf("long%0d req_ready k=%0d", id, k), 32'(req_ready), 32'(1 << id));
        chk($sformatf("long%0d frame_trunc k=%0d", id, k), 32'(frame_trunc), 0);
        k++;
      end
      cut = (k < nbytes);
    end
    @(negedge clk); drive_lane(id, k, nbytes); #1;
    chk($sformatf("long%0d end tx_valid", id), 32'(tx_valid), 0);
    chk($sformatf("long%0d end frame_trunc", id), 32'(frame_trunc), 32'(cut));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    // rst vld    lst    dat            rdy  tv td     bsy gid rr
    // Requesters 0 and 2 each send 3 bytes; 0 wins first.
    add(1, 4'h5, 4'h0, 32'h00C0_00A0, 1,  0, 8'h00, 0,  0, 4'h0);
    add(0, 4'h5, 4'h0, 32'h00C0_00A0, 1,  0, 8'h00, 0,  0, 4'h0);
    add(0, 4'h5, 4'h0, 32'h00C0_00A0, 1,  1, 8'hA0, 1,  0, 4'h1);
    add(0, 4'h5, 4'h0, 32'h00C0_00A1, 1,  1, 8'hA1, 1,  0, 4'h1);
    add(0, 4'h5, 4'h1, 32'h00C0_00A2, 1,  1, 8'hA2, 1,  0, 4'h1);
    add(0, 4'h4, 4'h0, 32'h00C0_0000, 1,  0, 8'h00, 0,  0, 4'h0);
    add(0, 4'h4, 4'h0, 32'h00C0_0000, 1,  1, 8'hC0, 1,  2, 4'h4);
    add(0, 4'h4, 4'h0, 32'h00C1_0000, 1,  1, 8'hC1, 1,  2, 4'h4);
    add(0, 4'h4, 4'h4, 32'h00C2_0000, 1,  1, 8'hC2, 1,  2, 4'h4);
    add(0, 4'h0, 4'h0, 32'h0000_0000, 0,  0, 8'h00, 0,  0, 4'h0);
    // tx_ready 1,0,0,1 mid-frame on requester 1 (pointer at 3 wraps to 1)
    add(0, 4'h2, 4'h0, 32'h0000_B000, 1,  0, 8'h00, 0,  0, 4'h0);
    add(0, 4'h2, 4'h0, 32'h0000_B000, 1,  1, 8'hB0, 1,  1, 4'h2);
    add(0, 4'h2, 4'h0, 32'h0000_B100, 0,  1, 8'hB1, 1,  1, 4'h0);
    add(0, 4'h2, 4'h0, 32'h0000_B100, 0,  1, 8'hB1, 1,  1, 4'h0);
    add(0, 4'h2, 4'h0, 32'h0000_B100, 1,  1, 8'hB1, 1,  1, 4'h2);
    add(0, 4'h2, 4'h2, 32'h0000_B200, 1,  1, 8'hB2, 1,  1, 4'h2);
    add(0, 4'h0, 4'h0, 32'h0000_0000, 1,  0, 8'h00, 0,  0, 4'h0);
    // Reset, then all four with 1-byte frames: 0,1,2,3,0, two cycles each
    add(1, 4'hF, 4'hF, 32'h4342_4140, 1,  0, 8'h00, 0,  0, 4'h0);
    add(0, 4'hF, 4'hF, 32'h4342_4140, 1,  0, 8'h00, 0,  0, 4'h0);
    add(0, 4'hF, 4'hF, 32'h4342_4140, 1,  1, 8'h40, 1,  0, 4'h1);
    add(0, 4'hF, 4'hF, 32'h4342_4140, 1,  0, 8'h00, 0,  0, 4'h0);
    add(0, 4'hF, 4'hF, 32'h4342_4140, 1,  1, 8'h41, 1,  1, 4'h2);
    add(0, 4'hF, 4'hF, 32'h4342_4140, 1,  0, 8'h00, 0,  0, 4'h0);
    add(0, 4'hF, 4'hF, 32'h4342_4140, 1,  1, 8'h42, 1,  2, 4'h4);
    add(0, 4'hF, 4'hF, 32'h4342_4140, 1,  0, 8'h00, 0,  0, 4'h0);
    add(0, 4'hF, 4'hF, 32'h4342_4140, 1,  1, 8'h43, 1,  3, 4'h8);
    add(0, 4'hF, 4'hF, 32'h4342_4140, 1,  0, 8'h00, 0,  0, 4'h0);
    add(0, 4'hF, 4'hF, 32'h4342_4140, 1,  1, 8'h40, 1,  0, 4'h1);
    add(0, 4'h0, 4'h0, 32'h0000_0000, 1,  0, 8'h00, 0,  0, 4'h0);
    // Requester 2 starts a 5-byte frame; reset after byte 2, then 0 wins
    add(0, 4'h4, 4'h0, 32'h00E0_0000, 1,  0, 8'h00, 0,  0, 4'h0);
    add(0, 4'h4, 4'h0, 32'h00E0_0000, 1,  1, 8'hE0, 1,  2, 4'h4);
    add(0, 4'h4, 4'h0, 32'h00E1_0000, 1,  1, 8'hE1, 1,  2, 4'h4);
    add(1, 4'h4, 4'h0, 32'h00E2_0000, 1,  0, 8'h00, 0,  0, 4'h0);
    add(0, 4'h5, 4'h1, 32'h00E0_00F0, 1,  0, 8'h00, 0,  0, 4'h0);
    add(0, 4'h5, 4'h1, 32'h00E0_00F0, 1,  1, 8'hF0, 1,  0, 4'h1);
    add(0, 4'h0, 4'h0, 32'h0000_0000, 1,  0, 8'h00, 0,  0, 4'h0);

    foreach (tbl[r]) begin
      @(negedge clk);
      reset_n   = !tbl[r].rst;
      req_valid = tbl[r].vld;
      req_last  = tbl[r].lst;
      req_data  = tbl[r].dat;
      tx_ready  = tbl[r].rdy;
      #1;
      chk($sformatf("row%0d tx_valid", r), 32'(tx_valid), 32'(tbl[r].e_tv));
      if (tbl[r].e_tv) chk($sformatf("row%0d tx_data", r), 32'(tx_data), 32'(tbl[r].e_td));
      chk($sformatf("row%0d busy", r), 32'(busy), 32'(tbl[r].e_busy));
      chk($sformatf("row%0d req_ready", r), 32'(req_ready), 32'(tbl[r].e_rr));
      chk($sformatf("row%0d frame_trunc", r), 32'(frame_trunc), 0);
      if (tbl[r].e_busy || tbl[r].rst)
        chk($sformatf("row%0d grant_id", r), 32'(grant_id), 32'(tbl[r].e_gid));
    end

    // 20 bytes without an early last: cut at 16, re-grant for the last 4
    send_long(1, 20);
    // last byte lands exactly on the limit: normal end, no trunc
    send_long(3, 16);

`ifdef ICEBOARD_ARB_TIMEOUT_EN
    // Owner 0 sends one byte then goes silent; requester 1 waits.
    tx_ready = 1'b1;
    @(negedge clk);
    req_valid = 4'h3; req_last = 4'h0; req_data = 32'h0000_2211; #1;
    chk("to idle tx_valid", 32'(tx_valid), 0);
    @(negedge clk); #1;
    chk("to byte1 tx_data", 32'(tx_data), 32'h11);
    chk("to byte1 grant_id", 32'(grant_id), 0);
    for (int s = 0; s < 8; s++) begin
      @(negedge clk); req_valid = 4'h2; #1;
      chk($sformatf("to stall%0d tx_valid", s), 32'(tx_valid), 0);
      chk($sformatf("to stall%0d busy", s), 32'(busy), 1);
      chk($sformatf("to stall%0d req_ready", s), 32'(req_ready), 0);
      chk($sformatf("to stall%0d frame_trunc", s), 32'(frame_trunc), 0);
    end
    @(negedge clk); #1;
    chk("to abort frame_trunc", 32'(frame_trunc), 1);
    chk("to abort tx_valid", 32'(tx_valid), 0);
    @(negedge clk); req_last = 4'h2; #1;
    chk("to idle2 frame_trunc", 32'(frame_trunc), 0);
    chk("to idle2 tx_valid", 32'(tx_valid), 0);
    @(negedge clk); #1;
    chk("to next grant_id", 32'(grant_id), 1);
    chk("to next tx_data", 32'(tx_data), 32'h22);
    chk("to next req_ready", 32'(req_ready), 32'h2);
    @(negedge clk); req_valid = '0; req_last = '0; #1;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
